// File: rtl/dp_cache_responder.sv
// ----------------------------------------------------------------------------
// dp_cache_responder
//
// Responder end of the datapath/cache request interface. Instruction and data
// requests from the pipelined datapath are arbitrated onto one single-ported
// RAM channel. The RAM signals completion with ramready. The datapath gets a
// one-cycle ihit/dhit pulse together with registered load data.
//
// Parameters:
//   RAM_AW    : word-address bits on ramaddr (byte address bits [RAM_AW+1:2])
//   DATA_PRIO : 1 = data request wins a same-cycle tie, 0 = instruction wins
//
// Optional feature (macro DP_IBUF_EN):
//   Adds a one-entry instruction buffer. A fetch that matches the buffer skips
//   the RAM and answers in IRESP directly. A completed data write to the
//   buffered word invalidates the entry.
//
// Ports:
//   CLK, nRST               : clock, asynchronous active-low reset
//   imemREN, imemaddr       : instruction read request (level) and byte address
//   dmemREN, dmemWEN        : data read / write request (level)
//   dmemaddr, dmemstore     : data byte address and write value
//   halt                    : datapath halted, stops all further RAM traffic
//   ihit, imemload          : instruction hit pulse and instruction word
//   dhit, dmemload          : data hit pulse and load word
//   ramREN, ramWEN          : RAM read / write strobes
//   ramaddr, ramstore       : RAM word address and write data
//   ramload, ramready       : RAM read data and access-complete flag
// ----------------------------------------------------------------------------
module dp_cache_responder #(
    parameter int RAM_AW    = 16,
    parameter int DATA_PRIO = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [31:0]       dmemaddr,
    input  logic [31:0]       dmemstore,
    input  logic              halt,
    output logic              ihit,
    output logic              dhit,
    output logic [31:0]       imemload,
    output logic [31:0]       dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [RAM_AW-1:0] ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic              ramready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IREQ   = 3'd1,
        DREQ   = 3'd2,
        IRESP  = 3'd3,
        DRESP  = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              halt_pend_q, halt_pend_d;
    logic              ihit_q, ihit_d;
    logic              dhit_q, dhit_d;
    logic [31:0]       imemload_q, imemload_d;
    logic [31:0]       dmemload_q, dmemload_d;
    logic              ramren_q, ramren_d;
    logic              ramwen_q, ramwen_d;
    logic [RAM_AW-1:0] ramaddr_q, ramaddr_d;
    logic [31:0]       ramstore_q, ramstore_d;

    logic              dreq_s;
    logic              dsel_s;
    logic              prio_data_s;
    logic              halt_any_s;

`ifdef DP_IBUF_EN
    logic [29:0]       req_tag_q, req_tag_d;
    logic [29:0]       ibuf_tag_q, ibuf_tag_d;
    logic              ibuf_vld_q, ibuf_vld_d;
    logic [31:0]       ibuf_word_q, ibuf_word_d;
    logic              ibuf_hit_s;
    logic [3:0]        unused_addr_bits_s;

    assign ibuf_hit_s         = ibuf_vld_q && (ibuf_tag_q == imemaddr[31:2]);
    assign unused_addr_bits_s = {imemaddr[1:0], dmemaddr[1:0]};
`else
    logic [63-2*RAM_AW:0] unused_addr_bits_s;

    assign unused_addr_bits_s = {imemaddr[31:RAM_AW+2], imemaddr[1:0],
                                 dmemaddr[31:RAM_AW+2], dmemaddr[1:0]};
`endif

    assign prio_data_s = (DATA_PRIO != 0);
    assign dreq_s      = dmemREN | dmemWEN;
    // A data request is taken unless an instruction request ties with it and
    // instructions have priority.
    assign dsel_s      = dreq_s & (prio_data_s | ~imemREN);
    // halt seen at any time during an access is remembered so the access can
    // finish before parking in HALTED.
    assign halt_any_s  = halt | halt_pend_q;

    // Next-state, request latching and registered-output computation.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        halt_pend_d = halt_pend_q | halt;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        imemload_d  = imemload_q;
        dmemload_d  = dmemload_q;
        ramren_d    = ramren_q;
        ramwen_d    = ramwen_q;
        ramaddr_d   = ramaddr_q;
        ramstore_d  = ramstore_q;
`ifdef DP_IBUF_EN
        req_tag_d   = req_tag_q;
        ibuf_tag_d  = ibuf_tag_q;
        ibuf_vld_d  = ibuf_vld_q;
        ibuf_word_d = ibuf_word_q;
`endif

        case (state_q)
            IDLE: begin
                if (halt_any_s) begin
                    state_d  = HALTED;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                end else if (dsel_s) begin
                    // A simultaneous read+write is a write.
                    state_d    = DREQ;
                    wr_d       = dmemWEN;
                    ramren_d   = ~dmemWEN;
                    ramwen_d   = dmemWEN;
                    ramaddr_d  = dmemaddr[RAM_AW+1:2];
                    ramstore_d = dmemstore;
`ifdef DP_IBUF_EN
                    req_tag_d  = dmemaddr[31:2];
`endif
                end else if (imemREN) begin
`ifdef DP_IBUF_EN
                    if (ibuf_hit_s) begin
                        // Buffered word answers without touching the RAM.
                        state_d    = IRESP;
                        ihit_d     = 1'b1;
                        imemload_d = ibuf_word_q;
                        ramren_d   = 1'b0;
                        ramwen_d   = 1'b0;
                    end else begin
                        state_d    = IREQ;
                        wr_d       = 1'b0;
                        ramren_d   = 1'b1;
                        ramwen_d   = 1'b0;
                        ramaddr_d  = imemaddr[RAM_AW+1:2];
                        ramstore_d = 32'h0000_0000;
                        req_tag_d  = imemaddr[31:2];
                    end
`else
                    state_d    = IREQ;
                    wr_d       = 1'b0;
                    ramren_d   = 1'b1;
                    ramwen_d   = 1'b0;
                    ramaddr_d  = imemaddr[RAM_AW+1:2];
                    ramstore_d = 32'h0000_0000;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            IREQ: begin
                if (ramready) begin
                    state_d    = IRESP;
                    ihit_d     = 1'b1;
                    imemload_d = ramload;
                    ramren_d   = 1'b0;
                    ramwen_d   = 1'b0;
`ifdef DP_IBUF_EN
                    ibuf_vld_d  = 1'b1;
                    ibuf_tag_d  = req_tag_q;
                    ibuf_word_d = ramload;
`endif
                end else begin
                    state_d = IREQ;
                end
            end

            DREQ: begin
                if (ramready) begin
                    state_d  = DRESP;
                    dhit_d   = 1'b1;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    if (!wr_q) begin
                        dmemload_d = ramload;
                    end else begin
                        dmemload_d = dmemload_q;
                    end
`ifdef DP_IBUF_EN
                    // A completed write to the buffered word makes it stale.
                    if (wr_q && (ibuf_tag_q == req_tag_q)) begin
                        ibuf_vld_d = 1'b0;
                    end else begin
                        ibuf_vld_d = ibuf_vld_q;
                    end
`endif
                end else begin
                    state_d = DREQ;
                end
            end

            IRESP, DRESP: begin
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
                if (halt_any_s) begin
                    state_d = HALTED;
                end else begin
                    state_d = IDLE;
                end
            end

            HALTED: begin
                state_d  = HALTED;
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every strobe at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            halt_pend_q <= 1'b0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            imemload_q  <= 32'h0000_0000;
            dmemload_q  <= 32'h0000_0000;
            ramren_q    <= 1'b0;
            ramwen_q    <= 1'b0;
            ramaddr_q   <= '0;
            ramstore_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            halt_pend_q <= halt_pend_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            imemload_q  <= imemload_d;
            dmemload_q  <= dmemload_d;
            ramren_q    <= ramren_d;
            ramwen_q    <= ramwen_d;
            ramaddr_q   <= ramaddr_d;
            ramstore_q  <= ramstore_d;
        end
    end

`ifdef DP_IBUF_EN
    // Instruction buffer registers; reset invalidates the entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_tag_q   <= 30'h0000_0000;
            ibuf_tag_q  <= 30'h0000_0000;
            ibuf_vld_q  <= 1'b0;
            ibuf_word_q <= 32'h0000_0000;
        end else begin
            req_tag_q   <= req_tag_d;
            ibuf_tag_q  <= ibuf_tag_d;
            ibuf_vld_q  <= ibuf_vld_d;
            ibuf_word_q <= ibuf_word_d;
        end
    end
`endif

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = imemload_q;
    assign dmemload = dmemload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;

endmodule

// File: tb/tb_dp_cache_responder.sv
// ----------------------------------------------------------------------------
// tb_dp_cache_responder
//
// Directed bench for dp_cache_responder with default parameters
// (RAM_AW=16, DATA_PRIO=1). The RAM side is driven directly by the stimulus.
// Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_dp_cache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [15:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    int vectors;
    int miscompares;

    dp_cache_responder dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .halt      (halt),
        .ihit      (ihit),
        .dhit      (dhit),
        .imemload  (imemload),
        .dmemload  (dmemload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramready  (ramready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST      = 1'b0;
        imemREN   = 1'b0;
        imemaddr  = 32'h0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = 32'h0;
        dmemstore = 32'h0;
        halt      = 1'b0;
        ramload   = 32'h0;
        ramready  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_strobes", {28'h0, ihit, dhit, ramREN, ramWEN}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        chk("rst_ramaddr", {16'h0, ramaddr}, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        nRST = 1'b1;
        tick();

        // Instruction read, zero-wait RAM
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        ramload  = 32'h8C22_0004;
        ramready = 1'b1;
        tick();
        chk("ird_ramren", {31'h0, ramREN}, 32'h1);
        chk("ird_ramwen", {31'h0, ramWEN}, 32'h0);
        chk("ird_ramaddr", {16'h0, ramaddr}, 32'h0000_0010);
        chk("ird_ihit_early", {31'h0, ihit}, 32'h0);
        tick();
        chk("ird_ihit", {31'h0, ihit}, 32'h1);
        chk("ird_imemload", imemload, 32'h8C22_0004);
        chk("ird_ramren_off", {31'h0, ramREN}, 32'h0);
        imemREN  = 1'b0;
        ramready = 1'b0;
        tick();
        chk("ird_ihit_pulse", {31'h0, ihit}, 32'h0);
        chk("ird_imemload_hold", imemload, 32'h8C22_0004);

        // Data write with two RAM wait cycles
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h0000_0F00;
        dmemstore = 32'hDEAD_BEEF;
        tick();
        chk("dwr_ramwen1", {30'h0, ramREN, ramWEN}, 32'h1);
        chk("dwr_ramaddr", {16'h0, ramaddr}, 32'h0000_03C0);
        chk("dwr_ramstore", ramstore, 32'hDEAD_BEEF);
        tick();
        chk("dwr_ramwen2", {30'h0, ramWEN, dhit}, 32'h2);
        tick();
        chk("dwr_ramwen3", {30'h0, ramWEN, dhit}, 32'h2);
        ramready = 1'b1;
        tick();
        chk("dwr_dhit", {30'h0, ramWEN, dhit}, 32'h1);
        chk("dwr_dmemload", dmemload, 32'h0);
        dmemWEN  = 1'b0;
        ramready = 1'b0;
        tick();
        chk("dwr_dhit_pulse", {31'h0, dhit}, 32'h0);

        // Data read, low address bits ignored
        dmemREN  = 1'b1;
        dmemaddr = 32'h0000_0F03;
        ramload  = 32'h1234_5678;
        ramready = 1'b1;
        tick();
        chk("drd_strobes", {30'h0, ramREN, ramWEN}, 32'h2);
        chk("drd_ramaddr", {16'h0, ramaddr}, 32'h0000_03C0);
        tick();
        chk("drd_dhit", {31'h0, dhit}, 32'h1);
        chk("drd_dmemload", dmemload, 32'h1234_5678);
        dmemREN = 1'b0;
        tick();

        // Read and write together is a write; dmemload untouched
        dmemREN   = 1'b1;
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h0000_0008;
        dmemstore = 32'hA5A5_A5A5;
        ramload   = 32'hFFFF_FFFF;
        tick();
        chk("drw_strobes", {30'h0, ramREN, ramWEN}, 32'h1);
        chk("drw_ramaddr", {16'h0, ramaddr}, 32'h0000_0002);
        tick();
        chk("drw_dhit", {31'h0, dhit}, 32'h1);
        chk("drw_dmemload", dmemload, 32'h1234_5678);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        tick();

        // Simultaneous requests: data first, then instruction
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0044;
        dmemREN  = 1'b1;
        dmemaddr = 32'h0000_0100;
        ramload  = 32'h1111_1111;
        ramready = 1'b1;
        tick();
        chk("sim_dreq", {30'h0, ramREN, ramWEN}, 32'h2);
        chk("sim_dreq_addr", {16'h0, ramaddr}, 32'h0000_0040);
        tick();
        chk("sim_dhit", {30'h0, ihit, dhit}, 32'h1);
        chk("sim_dmemload", dmemload, 32'h1111_1111);
        dmemREN = 1'b0;
        ramload = 32'h2222_2222;
        tick();
        chk("sim_idle", {29'h0, ihit, dhit, ramREN}, 32'h0);
        tick();
        chk("sim_ireq", {29'h0, ihit, dhit, ramREN}, 32'h1);
        chk("sim_ireq_addr", {16'h0, ramaddr}, 32'h0000_0011);
        tick();
        chk("sim_ihit", {30'h0, ihit, dhit}, 32'h2);
        chk("sim_imemload", imemload, 32'h2222_2222);
        imemREN  = 1'b0;
        ramready = 1'b0;
        tick();

        // halt during an instruction wait: hit still pulses, then no traffic
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        tick();
        chk("hlt_ireq", {31'h0, ramREN}, 32'h1);
        chk("hlt_ireq_addr", {16'h0, ramaddr}, 32'h0000_0020);
        halt = 1'b1;
        tick();
        chk("hlt_wait", {30'h0, ramREN, ihit}, 32'h2);
        ramready = 1'b1;
        ramload  = 32'hCAFE_F00D;
        tick();
        chk("hlt_ihit", {31'h0, ihit}, 32'h1);
        chk("hlt_imemload", imemload, 32'hCAFE_F00D);
        ramready = 1'b0;
        halt     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hlt_quiet", {28'h0, ramREN, ramWEN, ihit, dhit}, 32'h0);
        end

        // Leave HALTED through reset
        nRST    = 1'b0;
        imemREN = 1'b0;
        #2;
        nRST = 1'b1;
        tick();

        // Reset while a write is in progress
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h0000_0200;
        dmemstore = 32'h55AA_55AA;
        tick();
        chk("rma_ramwen", {31'h0, ramWEN}, 32'h1);
        #3;
        nRST = 1'b0;
        #1;
        chk("rma_ramwen_drop", {30'h0, ramREN, ramWEN}, 32'h0);
        chk("rma_ramaddr", {16'h0, ramaddr}, 32'h0);
        dmemWEN = 1'b0;
        #2;
        nRST = 1'b1;
        tick();
        chk("rma_outputs", {28'h0, ihit, dhit, ramREN, ramWEN}, 32'h0);
        chk("rma_loads", imemload | dmemload | ramstore, 32'h0);

        // Fetch 0x40 after reset goes to RAM
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        ramload  = 32'h8C22_0004;
        ramready = 1'b1;
        tick();
        chk("rf1_ramren", {31'h0, ramREN}, 32'h1);
        tick();
        chk("rf1_ihit", {31'h0, ihit}, 32'h1);
        chk("rf1_imemload", imemload, 32'h8C22_0004);
        imemREN = 1'b0;
        tick();

        // Repeat the fetch; RAM now returns a different word
        imemREN = 1'b1;
        ramload = 32'hDEAD_DEAD;
`ifdef DP_IBUF_EN
        tick();
        chk("buf_hit", {30'h0, ihit, ramREN}, 32'h2);
        chk("buf_word", imemload, 32'h8C22_0004);
        imemREN = 1'b0;
        tick();
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h0000_0040;
        dmemstore = 32'h0000_0000;
        tick();
        chk("buf_wr", {31'h0, ramWEN}, 32'h1);
        tick();
        chk("buf_wr_dhit", {31'h0, dhit}, 32'h1);
        dmemWEN = 1'b0;
        tick();
        imemREN = 1'b1;
`endif
        tick();
        chk("rf2_ramren", {30'h0, ihit, ramREN}, 32'h1);
        tick();
        chk("rf2_ihit", {31'h0, ihit}, 32'h1);
        chk("rf2_imemload", imemload, 32'hDEAD_DEAD);
        imemREN  = 1'b0;
        ramready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
